// File: rtl/seq_and_multiplier.sv
// seq_and_multiplier: multi-cycle shift-and-add multiplier.
// Each RUN cycle ANDs the multiplicand with the current low multiplier bit
// and adds it into the upper half of a 2*WIDTH accumulator, which then
// shifts right by one. WIDTH cycles in RUN, one cycle in FIN.
// Optional feature macro: MUL_SIGNED_EN (two's complement operands).
module seq_and_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_cap, b_cap;
  logic [2*WIDTH-1:0] result;

  // Partial product: one AND gate per multiplicand bit, gated by acc[0].
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = mcand_q[i] & acc_q[0];
  end

  // Carry is kept as the top bit so the shift never loses it.
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};

`ifdef MUL_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes are multiplied unsigned; -2^(W-1) maps to 2^(W-1), which fits.
  assign a_cap  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign b_cap  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign result = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

  // Sign of the result, latched with the operands.
  always_ff @(posedge clk) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end

  // New sign only on an accepted start.
  always_comb begin
    neg_d = neg_q;
    if (state_q == IDLE && start) neg_d = a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_cap  = a;
  assign b_cap  = b;
  assign result = acc_q;
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_cap;
          acc_d   = {{WIDTH{1'b0}}, b_cap};
          cnt_d   = CNT_INIT;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIN;
      end
      FIN: begin
        product_d = result;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_and_multiplier.sv
// tb_seq_and_multiplier: directed table-driven bench for seq_and_multiplier
// (WIDTH=32) plus hand-written sequences for ignored start, back-to-back
// and reset during RUN. Define MUL_SIGNED_EN for the signed vector table.
module tb_seq_and_multiplier;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk, rst, start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [2*W-1:0] product;

  int n_pass = 0;
  int n_tot  = 0;
  int edges  = 0;
  logic [2*W-1:0] last_prod = '0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  seq_and_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av; b = bv; start = 1'b1;
    edges = 0;
    tick();
    start = 1'b0;
  endtask

  // Waits for done counting edges since the accepted start; checks latency,
  // busy held high throughout, and the old result visible mid-run.
  task automatic wait_done(input string nm, input logic [2*W-1:0] exp);
    bit busy_ok = 1'b1;
    logic [2*W-1:0] mid = last_prod;
    while (!done && edges < 200) begin
      if (!busy) busy_ok = 1'b0;
      if (edges == 10) mid = product;
      tick();
    end
    chk({nm, " latency"}, 64'(edges), 64'(LAT));
    chk({nm, " product"}, product, exp);
    chk({nm, " busy low at done"}, 64'(busy), 64'(0));
    chk({nm, " busy during run"}, 64'(busy_ok), 64'(1));
    chk({nm, " old product mid-run"}, mid, last_prod);
    last_prod = exp;
  endtask

  initial begin
    bit saw_done;
`ifdef MUL_SIGNED_EN
    vecs[0] = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[4] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
`else
    vecs[0] = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[3] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
`endif

    // Reset then idle.
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("idle busy", 64'(busy), 64'(0));
      chk("idle done", 64'(done), 64'(0));
      chk("idle product", product, 64'(0));
      tick();
    end

    // Table-driven operations, each followed by a check that done is a pulse.
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      a = ~vecs[i].a; b = ~vecs[i].b;  // operands must not be re-sampled
      wait_done($sformatf("vec%0d", i), vecs[i].p);
      tick();
      chk($sformatf("vec%0d done pulse", i), 64'(done), 64'(0));
      chk($sformatf("vec%0d product held", i), product, vecs[i].p);
    end

    // Start while busy is ignored.
    start_op(32'd3, 32'd5);
    repeat (5) tick();
    a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0;
    wait_done("ignored start", 64'd15);

    // Start in the done cycle is accepted.
    start_op(32'd2, 32'd4);
    wait_done("back-to-back", 64'd8);
    tick();
    chk("b2b done pulse", 64'(done), 64'(0));

    // Reset in the middle of RUN.
    start_op(32'd100, 32'd100);
    while (edges < 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst mid busy", 64'(busy), 64'(0));
    chk("rst mid done", 64'(done), 64'(0));
    chk("rst mid product", product, 64'(0));
    last_prod = '0;
    saw_done = 1'b0;
    repeat (40) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    chk("rst mid no done", 64'(saw_done), 64'(0));
    start_op(32'd10, 32'd10);
    wait_done("after reset", 64'd100);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
